// File: rtl/softmax_row_sched_pkg.sv
// Shared types, widths and helpers for the softmax row scheduler.
package softmax_row_sched_pkg;

    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First valid index strictly after ptr, wrapping at n; ptr itself has lowest priority.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   vld,
                                                     input logic [MAX_IDX_W-1:0] ptr,
                                                     input int                   n);
        logic [MAX_IDX_W-1:0] pick;
        logic                 found;
        int                   j;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !found && vld[j]) begin
                pick  = MAX_IDX_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/softmax_row_sched_if.sv
// Requester, softmax and response signals of the row scheduler as one bundle.
interface softmax_row_sched_if
    import softmax_row_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*D_W_ACC-1:0] req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       sm_in_valid;
    logic [D_W_ACC-1:0]         sm_qin;
    logic                       sm_out_valid;
    logic [D_W-1:0]             sm_qout;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [D_W-1:0]             resp_data;
    logic                       resp_last;
    logic                       busy;
    logic                       err_gap;
    logic                       err_orphan;

    modport master (
        output req_valid, req_data, sm_out_valid, sm_qout,
        input  req_ready, sm_in_valid, sm_qin, resp_valid, resp_data, resp_last,
               busy, err_gap, err_orphan
    );

    modport slave (
        input  req_valid, req_data, sm_out_valid, sm_qout,
        output req_ready, sm_in_valid, sm_qin, resp_valid, resp_data, resp_last,
               busy, err_gap, err_orphan
    );
endinterface

// File: rtl/softmax_row_sched_tag_fifo.sv
// In-order FIFO of requester tags for rows in flight inside softmax.
module sched_tag_fifo
    import softmax_row_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_din,
    output logic [W-1:0]                 o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rd];

    // A pop in the same cycle frees the slot, so a push onto a full FIFO is legal then.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)  r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/softmax_row_sched.sv
// Round-robin row scheduler sharing one softmax between NUM_REQ score producers,
// routing each returned row back to its issuer through an in-order tag FIFO.
module softmax_row_sched
    import softmax_row_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int N         = 32,
    parameter int D_W       = 8,
    parameter int D_W_ACC   = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    softmax_row_sched_if.slave bus
);
    localparam int IDX_W  = idx_w(NUM_REQ);
    localparam int CNT_W  = cnt_w(N);
    localparam int TCNT_W = cnt_w(TAG_DEPTH);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_gnt;
    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_err_gap;
    logic              r_err_orphan;

    logic [MAX_REQ-1:0] w_vld_ext;
    logic [IDX_W-1:0]   w_pick;
    logic               w_stream;
    logic               w_gnt_vld;
    logic               w_xfer;
    logic               w_row_done;
    logic               w_grant;
    logic               w_out_hit;
    logic               w_out_last;
    logic [IDX_W-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic [TCNT_W-1:0]  w_count;

    assign w_vld_ext  = MAX_REQ'(bus.req_valid);
    assign w_pick     = IDX_W'(rr_pick(w_vld_ext, MAX_IDX_W'(r_ptr), NUM_REQ));
    assign w_stream   = (r_state == STREAM);
    assign w_gnt_vld  = bus.req_valid[r_gnt];
    assign w_xfer     = w_stream && w_gnt_vld;
    assign w_row_done = w_xfer && (r_in_cnt == CNT_W'(N - 1));

    assign w_out_hit  = bus.sm_out_valid && !w_empty;
    assign w_out_last = w_out_hit && (r_out_cnt == CNT_W'(N - 1));
    // The row-completing pop frees a tag slot for a grant in the same cycle.
    assign w_grant    = !w_stream && (|bus.req_valid) && (!w_full || w_out_last);

    sched_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDX_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_pop   (w_out_last),
        .i_din   (w_pick),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.req_ready   = w_stream ? NUM_REQ'(onehot(MAX_IDX_W'(r_gnt))) : '0;
    assign bus.sm_in_valid = w_xfer;
    assign bus.sm_qin      = w_stream ? bus.req_data[r_gnt*D_W_ACC +: D_W_ACC] : '0;
    assign bus.resp_valid  = w_out_hit ? NUM_REQ'(onehot(MAX_IDX_W'(w_head))) : '0;
    assign bus.resp_data   = w_out_hit ? bus.sm_qout : '0;
    assign bus.resp_last   = w_out_last;
    assign bus.busy        = w_stream || (w_count != '0);
    assign bus.err_gap     = r_err_gap;
    assign bus.err_orphan  = r_err_orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_err_gap    <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            if (!w_stream) begin
                if (w_grant) begin
                    r_gnt    <= w_pick;
                    r_ptr    <= w_pick;
                    r_in_cnt <= '0;
                    r_state  <= STREAM;
                end
            end else begin
                if (w_xfer)     r_in_cnt <= w_row_done ? '0 : r_in_cnt + 1'b1;
                if (w_row_done) r_state  <= IDLE;
                // A bubble before the first element is just a late start, not a gap.
                if (!w_gnt_vld && (r_in_cnt != '0)) r_err_gap <= 1'b1;
            end
            if (w_out_hit) r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
            if (bus.sm_out_valid && w_empty) r_err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_softmax_row_sched.sv
// Scoreboard bench: requester drivers, a row-buffering softmax model and a response monitor.
module tb_softmax_row_sched;
    localparam int NUM_REQ   = 4;
    localparam int N         = 32;
    localparam int D_W       = 8;
    localparam int D_W_ACC   = 32;
    localparam int TAG_DEPTH = 4;

    typedef struct packed {
        logic [NUM_REQ-1:0] vld;
        logic [D_W-1:0]     dat;
        logic               last;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softmax_row_sched_if #(.NUM_REQ(NUM_REQ), .D_W(D_W), .D_W_ACC(D_W_ACC)) bus ();

    softmax_row_sched #(
        .NUM_REQ(NUM_REQ), .N(N), .D_W(D_W), .D_W_ACC(D_W_ACC), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    resp_t      exp_q[$];
    int         rq[NUM_REQ][$];
    logic [7:0] pend[$];
    logic [7:0] mq[$];
    logic       hold   = 1'b0;
    logic       orphan = 1'b0;
    int         log_req[$];
    int         log_dat[$];
    int         log_cyc[$];
    int         last_cyc[$];

    // Model softmax transform: any fixed mapping works since the scheduler passes data through.
    function automatic logic [7:0] sm_f(input int x);
        logic [31:0] v;
        v = x;
        return v[7:0] + v[15:8];
    endfunction

    function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int lreq(input int i);
        return (i < log_req.size()) ? log_req[i] : -1;
    endfunction

    function automatic int ldat(input int i);
        return (i < log_dat.size()) ? log_dat[i] : -1;
    endfunction

    function automatic int lcyc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1000;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void drive();
        logic [NUM_REQ-1:0]         v;
        logic [NUM_REQ*D_W_ACC-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0 && rq[i][0] >= 0) begin
                v[i] = 1'b1;
                d[i*D_W_ACC +: D_W_ACC] = rq[i][0];
            end
        end
        bus.req_valid    = v;
        bus.req_data     = d;
        bus.sm_out_valid = orphan || (!hold && mq.size() > 0);
        bus.sm_qout      = orphan ? 8'hAA : ((mq.size() > 0) ? mq[0] : 8'h00);
    endfunction

    // A value of -1 in a requester queue is a one-cycle bubble while granted.
    task automatic load_row(input int r, input int base, input bit gap);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        for (int k = 0; k < N; k++) begin
            rq[r].push_back(base + k);
            if (gap && k == 10) begin
                rq[r].push_back(-1);
                rq[r].push_back(-1);
            end
            exp_q.push_back('{vld: oh, dat: sm_f(base + k), last: (k == N - 1)});
        end
    endtask

    task automatic clear_logs();
        log_req.delete();
        log_dat.delete();
        log_cyc.delete();
        last_cyc.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = !bus.busy && exp_q.size() == 0 && mq.size() == 0 &&
                   rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: not idle after %0d cycles, %0d responses outstanding",
                     name, budget, exp_q.size());
        end
        step();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers and model softmax share one process so each input has a single writer.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_ready[i] && rq[i].size() > 0 && (bus.req_valid[i] || rq[i][0] < 0))
                    void'(rq[i].pop_front());
            if (bus.sm_out_valid && !orphan && mq.size() > 0) void'(mq.pop_front());
            if (bus.sm_in_valid) begin
                pend.push_back(sm_f(int'(bus.sm_qin)));
                if (pend.size() == N) begin
                    foreach (pend[k]) mq.push_back(pend[k]);
                    pend.delete();
                end
            end
        end else begin
            pend.delete();
            mq.delete();
        end
        #1;
        drive();
    end

    always @(negedge clk) begin
        resp_t e;
        if (!rst) begin
            if (bus.sm_in_valid) begin
                log_req.push_back(oh2idx(bus.req_ready));
                log_dat.push_back(int'(bus.sm_qin));
                log_cyc.push_back(cyc);
            end
            if (bus.resp_last) last_cyc.push_back(cyc);
            if (bus.resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got resp_valid=%b, expected no response", bus.resp_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_valid", int'(bus.resp_valid), int'(e.vld));
                    chk("resp_data", int'(bus.resp_data), int'(e.dat));
                    chk("resp_last", int'(bus.resp_last), int'(e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int ld;
        int ord[5];
        drive();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_sm_in_valid", int'(bus.sm_in_valid), 0);
        chk("rst_sm_qin", int'(bus.sm_qin), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_last", int'(bus.resp_last), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err_gap", int'(bus.err_gap), 0);
        chk("rst_err_orphan", int'(bus.err_orphan), 0);
        rst = 1'b0;
        step();

        // Single row from requester 2, scores 0..31.
        clear_logs();
        load_row(2, 0, 1'b0);
        ld = cyc;
        drive();
        wait_idle("t1", 400);
        chk("t1_transfers", log_req.size(), 32);
        chk("t1_grant_latency", lcyc(0) - ld, 1);
        chk("t1_contiguous", lcyc(31) - lcyc(0), 31);
        bad = 0;
        for (int k = 0; k < N; k++) if (lreq(k) != 2 || ldat(k) != k) bad++;
        chk("t1_qin_sequence_bad", bad, 0);

        // Round robin from reset: all four valid, requester 0 has a second row queued.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
        ord = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) load_row(ord[j], 32'h100 * (j + 1), 1'b0);
        drive();
        wait_idle("t2", 1000);
        chk("t2_transfers", log_req.size(), 160);
        bad = 0;
        for (int j = 0; j < 5; j++)
            for (int m = 0; m < N; m++) if (lreq(j*N + m) != ord[j]) bad++;
        chk("t2_grant_order_bad", bad, 0);
        bad = 0;
        for (int j = 1; j < 5; j++) if (lcyc(j*N) - lcyc((j-1)*N) != 33) bad++;
        chk("t2_row_period_bad", bad, 0);

        // Backpressure: softmax output held, the fifth row waits for the first row's last result.
        clear_logs();
        hold = 1'b1;
        ord = '{1, 2, 3, 0, 1};
        for (int j = 0; j < 5; j++) load_row(ord[j], 32'h1000 + 32'h100 * j, 1'b0);
        drive();
        for (int i = 0; i < 400 && log_req.size() < 128; i++) @(posedge clk);
        repeat (40) @(posedge clk);
        #2;
        chk("t3_blocked_transfers", log_req.size(), 128);
        chk("t3_blocked_req_ready", int'(bus.req_ready), 0);
        chk("t3_blocked_busy", int'(bus.busy), 1);
        hold = 1'b0;
        drive();
        wait_idle("t3", 1000);
        chk("t3_transfers", log_req.size(), 160);
        chk("t3_fifth_req", lreq(128), 1);
        chk("t3_pop_push_same_cycle",
            lcyc(128) - ((last_cyc.size() > 0) ? last_cyc[0] : -1000), 1);
        chk("t3_no_gap", int'(bus.err_gap), 0);

        // Gap: requester 1 drops valid for two cycles after element 10.
        clear_logs();
        load_row(1, 32'h2000, 1'b1);
        drive();
        wait_idle("t4", 400);
        chk("t4_err_gap", int'(bus.err_gap), 1);
        chk("t4_transfers", log_req.size(), 32);
        chk("t4_bubble_cycles", lcyc(11) - lcyc(10), 3);
        chk("t4_last_data", ldat(31), 32'h2000 + 31);

        // Orphan result with no row in flight.
        chk("t5_orphan_before", int'(bus.err_orphan), 0);
        orphan = 1'b1;
        drive();
        @(negedge clk);
        chk("t5_orphan_resp_valid", int'(bus.resp_valid), 0);
        step();
        orphan = 1'b0;
        drive();
        @(negedge clk);
        chk("t5_err_orphan", int'(bus.err_orphan), 1);
        step();

        // Reset in the middle of a row from requester 2.
        clear_logs();
        load_row(2, 32'h3000, 1'b0);
        drive();
        for (int i = 0; i < 200 && log_req.size() < 16; i++) @(negedge clk);
        step();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        exp_q.delete();
        drive();
        step();
        chk("t6_req_ready", int'(bus.req_ready), 0);
        chk("t6_sm_in_valid", int'(bus.sm_in_valid), 0);
        chk("t6_resp_valid", int'(bus.resp_valid), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_err_gap", int'(bus.err_gap), 0);
        chk("t6_err_orphan", int'(bus.err_orphan), 0);
        rst = 1'b0;
        clear_logs();
        load_row(0, 32'h4000, 1'b0);
        load_row(3, 32'h4100, 1'b0);
        drive();
        wait_idle("t6", 400);
        chk("t6_first_grant", lreq(0), 0);
        chk("t6_second_grant", lreq(32), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
